// File: rtl/axi_arb_2to1_if.sv
// rtl/axi_arb_2to1_if.sv - AXI4 bundle shared by the two master ports and the slave port of the arbiter
interface axi_arb_2to1_if #(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_DATA_WD = 32,
    parameter int AXI_ADDR_WD = 32,
    parameter int AXI_STRB_WD = 4
);
    logic [AXI_ADDR_WD-1:0] awaddr;
    logic [AXI_ID_WD-1:0]   awid;
    logic [1:0]             awburst;
    logic [2:0]             awsize;
    logic [7:0]             awlen;
    logic                   awvalid;
    logic                   awready;

    logic [AXI_DATA_WD-1:0] wdata;
    logic [AXI_STRB_WD-1:0] wstrb;
    logic                   wlast;
    logic                   wvalid;
    logic                   wready;

    logic [AXI_ID_WD-1:0]   bid;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;

    logic [AXI_ADDR_WD-1:0] araddr;
    logic [AXI_ID_WD-1:0]   arid;
    logic [1:0]             arburst;
    logic [2:0]             arsize;
    logic [7:0]             arlen;
    logic                   arvalid;
    logic                   arready;

    logic [AXI_DATA_WD-1:0] rdata;
    logic [AXI_ID_WD-1:0]   rid;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awid, awburst, awsize, awlen, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output araddr, arid, arburst, arsize, arlen, arvalid, input arready,
        input  rdata, rid, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awaddr, awid, awburst, awsize, awlen, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  araddr, arid, arburst, arsize, arlen, arvalid, output arready,
        output rdata, rid, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_arb_2to1.sv
// rtl/axi_arb_2to1.sv - two-master round-robin AXI4 arbiter with burst-locked write and read grants
module axi_arb_2to1 (
    input  logic                 ACLK,
    input  logic                 ARESET,
    axi_arb_2to1_if.slave        s0_axi,
    axi_arb_2to1_if.slave        s1_axi,
    axi_arb_2to1_if.master       m_axi
);
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

    wstate_t wstate_q, wstate_d;
    rstate_t rstate_q, rstate_d;
    logic    wgnt_q, wgnt_d, wprio_q, wprio_d;
    logic    rgnt_q, rgnt_d, rprio_q, rprio_d;

    logic w_sel_awvalid, w_sel_wvalid, w_sel_bready;
    logic r_sel_arvalid, r_sel_rready;
    logic w_in_addr, w_in_data, w_in_resp, r_in_addr, r_in_data;

    assign w_sel_awvalid = wgnt_q ? s1_axi.awvalid : s0_axi.awvalid;
    assign w_sel_wvalid  = wgnt_q ? s1_axi.wvalid  : s0_axi.wvalid;
    assign w_sel_bready  = wgnt_q ? s1_axi.bready  : s0_axi.bready;
    assign r_sel_arvalid = rgnt_q ? s1_axi.arvalid : s0_axi.arvalid;
    assign r_sel_rready  = rgnt_q ? s1_axi.rready  : s0_axi.rready;

    assign w_in_addr = (wstate_q == W_ADDR);
    assign w_in_data = (wstate_q == W_DATA);
    assign w_in_resp = (wstate_q == W_RESP);
    assign r_in_addr = (rstate_q == R_ADDR);
    assign r_in_data = (rstate_q == R_DATA);

    // Request payloads follow the grant register in every state, not only while forwarding
    assign m_axi.awaddr  = wgnt_q ? s1_axi.awaddr  : s0_axi.awaddr;
    assign m_axi.awid    = wgnt_q ? s1_axi.awid    : s0_axi.awid;
    assign m_axi.awburst = wgnt_q ? s1_axi.awburst : s0_axi.awburst;
    assign m_axi.awsize  = wgnt_q ? s1_axi.awsize  : s0_axi.awsize;
    assign m_axi.awlen   = wgnt_q ? s1_axi.awlen   : s0_axi.awlen;
    assign m_axi.wdata   = wgnt_q ? s1_axi.wdata   : s0_axi.wdata;
    assign m_axi.wstrb   = wgnt_q ? s1_axi.wstrb   : s0_axi.wstrb;
    assign m_axi.wlast   = wgnt_q ? s1_axi.wlast   : s0_axi.wlast;
    assign m_axi.araddr  = rgnt_q ? s1_axi.araddr  : s0_axi.araddr;
    assign m_axi.arid    = rgnt_q ? s1_axi.arid    : s0_axi.arid;
    assign m_axi.arburst = rgnt_q ? s1_axi.arburst : s0_axi.arburst;
    assign m_axi.arsize  = rgnt_q ? s1_axi.arsize  : s0_axi.arsize;
    assign m_axi.arlen   = rgnt_q ? s1_axi.arlen   : s0_axi.arlen;

    assign m_axi.awvalid = w_in_addr & w_sel_awvalid;
    assign m_axi.wvalid  = w_in_data & w_sel_wvalid;
    assign m_axi.bready  = w_in_resp & w_sel_bready;
    assign m_axi.arvalid = r_in_addr & r_sel_arvalid;
    assign m_axi.rready  = r_in_data & r_sel_rready;

    assign s0_axi.awready = w_in_addr & ~wgnt_q & m_axi.awready;
    assign s1_axi.awready = w_in_addr &  wgnt_q & m_axi.awready;
    assign s0_axi.wready  = w_in_data & ~wgnt_q & m_axi.wready;
    assign s1_axi.wready  = w_in_data &  wgnt_q & m_axi.wready;
    assign s0_axi.bvalid  = w_in_resp & ~wgnt_q & m_axi.bvalid;
    assign s1_axi.bvalid  = w_in_resp &  wgnt_q & m_axi.bvalid;
    assign s0_axi.arready = r_in_addr & ~rgnt_q & m_axi.arready;
    assign s1_axi.arready = r_in_addr &  rgnt_q & m_axi.arready;
    assign s0_axi.rvalid  = r_in_data & ~rgnt_q & m_axi.rvalid;
    assign s1_axi.rvalid  = r_in_data &  rgnt_q & m_axi.rvalid;

    // Response payloads are broadcast; only one master sees VALID, so the other ignores them
    assign s0_axi.bid   = m_axi.bid;
    assign s1_axi.bid   = m_axi.bid;
    assign s0_axi.bresp = m_axi.bresp;
    assign s1_axi.bresp = m_axi.bresp;
    assign s0_axi.rdata = m_axi.rdata;
    assign s1_axi.rdata = m_axi.rdata;
    assign s0_axi.rid   = m_axi.rid;
    assign s1_axi.rid   = m_axi.rid;
    assign s0_axi.rresp = m_axi.rresp;
    assign s1_axi.rresp = m_axi.rresp;
    assign s0_axi.rlast = m_axi.rlast;
    assign s1_axi.rlast = m_axi.rlast;

    always_comb begin
        wstate_d = wstate_q;
        wgnt_d   = wgnt_q;
        wprio_d  = wprio_q;
        case (wstate_q)
            W_IDLE: begin
                if (s0_axi.awvalid || s1_axi.awvalid) begin
                    wstate_d = W_ADDR;
                    wgnt_d   = (s0_axi.awvalid && s1_axi.awvalid) ? wprio_q : s1_axi.awvalid;
                end
            end
            W_ADDR: if (w_sel_awvalid && m_axi.awready) wstate_d = W_DATA;
            W_DATA: if (w_sel_wvalid && m_axi.wready && m_axi.wlast) wstate_d = W_RESP;
            W_RESP: begin
                if (m_axi.bvalid && w_sel_bready) begin
                    wstate_d = W_IDLE;
                    wprio_d  = ~wgnt_q;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rgnt_d   = rgnt_q;
        rprio_d  = rprio_q;
        case (rstate_q)
            R_IDLE: begin
                if (s0_axi.arvalid || s1_axi.arvalid) begin
                    rstate_d = R_ADDR;
                    rgnt_d   = (s0_axi.arvalid && s1_axi.arvalid) ? rprio_q : s1_axi.arvalid;
                end
            end
            R_ADDR: if (r_sel_arvalid && m_axi.arready) rstate_d = R_DATA;
            R_DATA: begin
                if (m_axi.rvalid && r_sel_rready && m_axi.rlast) begin
                    rstate_d = R_IDLE;
                    rprio_d  = ~rgnt_q;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q <= W_IDLE;
            wgnt_q   <= 1'b0;
            wprio_q  <= 1'b0;
            rstate_q <= R_IDLE;
            rgnt_q   <= 1'b0;
            rprio_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            wgnt_q   <= wgnt_d;
            wprio_q  <= wprio_d;
            rstate_q <= rstate_d;
            rgnt_q   <= rgnt_d;
            rprio_q  <= rprio_d;
        end
    end
endmodule

// File: tb/tb_axi_arb_2to1.sv
// tb/tb_axi_arb_2to1.sv - directed bench for axi_arb_2to1 with two bench masters and a simple slave model
module tb_axi_arb_2to1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_arb_2to1_if s0_if ();
    axi_arb_2to1_if s1_if ();
    axi_arb_2to1_if m_if ();

    axi_arb_2to1 dut (.ACLK(clk), .ARESET(rst), .s0_axi(s0_if), .s1_axi(s1_if), .m_axi(m_if));

    logic [31:0] awaddr[2], wdata[2], araddr[2];
    logic [1:0]  awid[2], arid[2];
    logic [7:0]  awlen[2], arlen[2];
    logic        awvalid[2], wlast[2], wvalid[2], bready[2], arvalid[2], rready[2];
    logic        awready_o[2], wready_o[2], bvalid_o[2], arready_o[2], rvalid_o[2];

    assign s0_if.awaddr = awaddr[0]; assign s0_if.awid = awid[0]; assign s0_if.awlen = awlen[0]; assign s0_if.awvalid = awvalid[0];
    assign s0_if.awburst = 2'b01; assign s0_if.awsize = 3'b010; assign s0_if.wstrb = 4'hF; assign s0_if.arburst = 2'b01; assign s0_if.arsize = 3'b010;
    assign s0_if.wdata = wdata[0]; assign s0_if.wlast = wlast[0]; assign s0_if.wvalid = wvalid[0]; assign s0_if.bready = bready[0];
    assign s0_if.araddr = araddr[0]; assign s0_if.arid = arid[0]; assign s0_if.arlen = arlen[0]; assign s0_if.arvalid = arvalid[0]; assign s0_if.rready = rready[0];
    assign s1_if.awaddr = awaddr[1]; assign s1_if.awid = awid[1]; assign s1_if.awlen = awlen[1]; assign s1_if.awvalid = awvalid[1];
    assign s1_if.awburst = 2'b01; assign s1_if.awsize = 3'b010; assign s1_if.wstrb = 4'hF; assign s1_if.arburst = 2'b01; assign s1_if.arsize = 3'b010;
    assign s1_if.wdata = wdata[1]; assign s1_if.wlast = wlast[1]; assign s1_if.wvalid = wvalid[1]; assign s1_if.bready = bready[1];
    assign s1_if.araddr = araddr[1]; assign s1_if.arid = arid[1]; assign s1_if.arlen = arlen[1]; assign s1_if.arvalid = arvalid[1]; assign s1_if.rready = rready[1];

    assign awready_o[0] = s0_if.awready; assign wready_o[0] = s0_if.wready; assign bvalid_o[0] = s0_if.bvalid;
    assign arready_o[0] = s0_if.arready; assign rvalid_o[0] = s0_if.rvalid;
    assign awready_o[1] = s1_if.awready; assign wready_o[1] = s1_if.wready; assign bvalid_o[1] = s1_if.bvalid;
    assign arready_o[1] = s1_if.arready; assign rvalid_o[1] = s1_if.rvalid;

    // Bench-side records filled by the master tasks and the slave model
    int          aw_lat[2], ar_lat[2], aw_hs_cyc[2], w_end_cyc[2], b_hs_cyc[2], ar_hs_cyc[2], r_end_cyc[2];
    bit          aw_done[2];
    logic [31:0] rd_data[2][16];
    logic [1:0]  rd_id[2];
    logic [15:0] rd_last[2];
    int          rd_cnt[2];
    int          s1_seen = 0, s0_rv_seen = 0, early_viol = 0;

    // Slave model: AW when idle, W after AW, B one cycle after WLAST, R data = base address + beat index
    bit          sl_aw_busy = 0, sl_b_pend = 0, sl_r_act = 0;
    logic [1:0]  sl_bid = 0, sl_rid = 0;
    logic [31:0] sl_raddr = 0, sl_awaddr_log = 0;
    logic [7:0]  sl_rlen = 0, sl_ridx = 0, sl_awlen_log = 0;
    logic [31:0] sl_wlog[32];
    int          sl_wcnt = 0, sl_wlast_idx = -1;

    initial begin
        m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bid = 0; m_if.bresp = 0;
        m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rlast = 0; m_if.rid = 0; m_if.rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sl_aw_busy = 0; sl_b_pend = 0; sl_r_act = 0; sl_ridx = 0;
            end
            m_if.awready = !sl_aw_busy;
            m_if.wready  = sl_aw_busy && !sl_b_pend;
            m_if.bvalid  = sl_b_pend;
            m_if.bid     = sl_bid;
            m_if.arready = !sl_r_act;
            m_if.rvalid  = sl_r_act;
            m_if.rdata   = sl_raddr + {24'd0, sl_ridx};
            m_if.rlast   = sl_r_act && (sl_ridx == sl_rlen);
            m_if.rid     = sl_rid;
            #4;
            if (!rst) begin
                if (m_if.awvalid && m_if.awready) begin
                    sl_aw_busy = 1; sl_bid = m_if.awid; sl_awaddr_log = m_if.awaddr; sl_awlen_log = m_if.awlen;
                end
                if (m_if.wvalid && m_if.wready) begin
                    if (sl_wcnt < 32) sl_wlog[sl_wcnt] = m_if.wdata;
                    if (m_if.wlast) begin sl_b_pend = 1; sl_wlast_idx = sl_wcnt; end
                    sl_wcnt++;
                end
                if (m_if.bvalid && m_if.bready) begin sl_b_pend = 0; sl_aw_busy = 0; end
                if (m_if.rvalid && m_if.rready) begin
                    if (sl_ridx == sl_rlen) sl_r_act = 0;
                    else sl_ridx = sl_ridx + 8'd1;
                end
                if (m_if.arvalid && m_if.arready) begin
                    sl_r_act = 1; sl_raddr = m_if.araddr; sl_rlen = m_if.arlen; sl_ridx = 0; sl_rid = m_if.arid;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (awready_o[1] || wready_o[1] || bvalid_o[1] || arready_o[1] || rvalid_o[1]) s1_seen++;
            if (rvalid_o[0]) s0_rv_seen++;
            if (wready_o[1] && !aw_done[1]) early_viol++;
        end
    end

    task automatic mw_write(input int m, input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] base, output logic [1:0] bid_got);
        int n;
        bit hs;
        bid_got = 2'bxx;
        aw_done[m] = 0;
        awvalid[m] = 1; awid[m] = id; awaddr[m] = addr; awlen[m] = len;
        n = 0; hs = 0;
        while (!hs && n < 100) begin
            #4; hs = awready_o[m];
            if (hs) aw_hs_cyc[m] = cyc; else n++;
            @(negedge clk);
        end
        aw_lat[m] = n; awvalid[m] = 0;
        if (!hs) begin total++; bad++; $display("FAIL aw_timeout m%0d: no AWREADY within %0d cycles", m, n); return; end
        aw_done[m] = 1;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid[m] = 1; wdata[m] = base + i; wlast[m] = (i == int'(len));
            n = 0; hs = 0;
            while (!hs && n < 100) begin
                #4; hs = wready_o[m];
                if (hs) w_end_cyc[m] = cyc; else n++;
                @(negedge clk);
            end
            if (!hs) begin
                wvalid[m] = 0; wlast[m] = 0; total++; bad++;
                $display("FAIL w_timeout m%0d beat %0d: no WREADY", m, i); return;
            end
        end
        wvalid[m] = 0; wlast[m] = 0;
        bready[m] = 1; n = 0; hs = 0;
        while (!hs && n < 100) begin
            #4; hs = bvalid_o[m];
            if (hs) begin b_hs_cyc[m] = cyc; bid_got = (m == 0) ? s0_if.bid : s1_if.bid; end else n++;
            @(negedge clk);
        end
        bready[m] = 0;
        if (!hs) begin total++; bad++; $display("FAIL b_timeout m%0d: no BVALID", m); end
    endtask

    task automatic mr_read(input int m, input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len, input bit toggle);
        int n;
        bit hs, done, rv;
        arvalid[m] = 1; arid[m] = id; araddr[m] = addr; arlen[m] = len;
        n = 0; hs = 0;
        while (!hs && n < 100) begin
            #4; hs = arready_o[m];
            if (hs) ar_hs_cyc[m] = cyc; else n++;
            @(negedge clk);
        end
        ar_lat[m] = n; arvalid[m] = 0;
        if (!hs) begin total++; bad++; $display("FAIL ar_timeout m%0d: no ARREADY", m); return; end
        rd_cnt[m] = 0; rd_last[m] = 0; done = 0; n = 0;
        rready[m] = 1;
        while (!done && n < 200) begin
            #4; rv = rvalid_o[m];
            if (rv && rready[m] && rd_cnt[m] < 16) begin
                rd_data[m][rd_cnt[m]] = (m == 0) ? s0_if.rdata : s1_if.rdata;
                rd_last[m][rd_cnt[m]] = (m == 0) ? s0_if.rlast : s1_if.rlast;
                rd_id[m] = (m == 0) ? s0_if.rid : s1_if.rid;
                done = rd_last[m][rd_cnt[m]];
                r_end_cyc[m] = cyc;
                rd_cnt[m]++;
            end
            @(negedge clk);
            n++;
            if (toggle) rready[m] = !rready[m];
        end
        rready[m] = 0;
        if (!done) begin total++; bad++; $display("FAIL r_timeout m%0d: RLAST not seen, beats=%0d", m, rd_cnt[m]); end
    endtask

    task automatic test_reset();
        logic [9:0] s_flags;
        logic [4:0] m_flags;
        awaddr[0] = 32'h1234; awaddr[1] = 32'h5678; awvalid[0] = 1;
        @(negedge clk); #4;
        s_flags = {awready_o[0], wready_o[0], bvalid_o[0], arready_o[0], rvalid_o[0],
                   awready_o[1], wready_o[1], bvalid_o[1], arready_o[1], rvalid_o[1]};
        m_flags = {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
        total++; if (s_flags !== 10'd0) begin bad++; $display("FAIL reset_s_side: got %b want 0", s_flags); end
        total++; if (m_flags !== 5'd0) begin bad++; $display("FAIL reset_m_side: got %b want 0", m_flags); end
        total++; if (m_if.awaddr !== 32'h1234) begin bad++; $display("FAIL reset_payload: awaddr %h want 1234", m_if.awaddr); end
        @(negedge clk);
        awvalid[0] = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_simultaneous_write();
        logic [1:0] b0, b1;
        fork
            mw_write(0, 2'd1, 32'h100, 8'd1, 32'h10, b0);
            mw_write(1, 2'd2, 32'h200, 8'd1, 32'h20, b1);
        join
        total++; if (!(aw_hs_cyc[0] < aw_hs_cyc[1])) begin bad++; $display("FAIL tie1_order: m0 aw at %0d m1 aw at %0d, want m0 first", aw_hs_cyc[0], aw_hs_cyc[1]); end
        total++; if (aw_lat[0] !== 1) begin bad++; $display("FAIL tie1_m0_latency: got %0d want 1", aw_lat[0]); end
        total++; if (aw_hs_cyc[1] - b_hs_cyc[0] !== 2) begin bad++; $display("FAIL tie_turnaround: got %0d want 2", aw_hs_cyc[1] - b_hs_cyc[0]); end
        total++; if ({b0, b1} !== {2'd1, 2'd2}) begin bad++; $display("FAIL tie_bids: got %0d/%0d want 1/2", b0, b1); end
        fork
            mw_write(0, 2'd1, 32'h100, 8'd0, 32'h30, b0);
            mw_write(1, 2'd2, 32'h200, 8'd0, 32'h40, b1);
        join
        total++; if (!(aw_hs_cyc[0] < aw_hs_cyc[1])) begin bad++; $display("FAIL tie2_order: m0 aw at %0d m1 aw at %0d, want m0 first", aw_hs_cyc[0], aw_hs_cyc[1]); end
    endtask

    task automatic test_single_write();
        logic [1:0] b;
        sl_wcnt = 0; s1_seen = 0;
        mw_write(0, 2'd2, 32'h10, 8'd3, 32'hA0, b);
        total++; if (aw_lat[0] !== 1) begin bad++; $display("FAIL sw_aw_latency: got %0d want 1", aw_lat[0]); end
        total++; if ({sl_awaddr_log, sl_awlen_log} !== {32'h10, 8'd3}) begin bad++; $display("FAIL sw_aw_fields: addr %h len %0d want 10/3", sl_awaddr_log, sl_awlen_log); end
        total++; if (sl_wcnt !== 4) begin bad++; $display("FAIL sw_beat_count: got %0d want 4", sl_wcnt); end
        for (int i = 0; i < 4; i++) begin
            total++; if (sl_wlog[i] !== 32'hA0 + i) begin bad++; $display("FAIL sw_beat%0d: got %h want %h", i, sl_wlog[i], 32'hA0 + i); end
        end
        total++; if (sl_wlast_idx !== 3) begin bad++; $display("FAIL sw_wlast_pos: got %0d want 3", sl_wlast_idx); end
        total++; if (w_end_cyc[0] - aw_hs_cyc[0] !== 4) begin bad++; $display("FAIL sw_throughput: got %0d want 4", w_end_cyc[0] - aw_hs_cyc[0]); end
        total++; if (b !== 2'd2) begin bad++; $display("FAIL sw_bid: got %0d want 2", b); end
        total++; if (s1_seen !== 0) begin bad++; $display("FAIL sw_s1_quiet: got %0d active cycles want 0", s1_seen); end
    endtask

    task automatic test_read_backpressure();
        s0_rv_seen = 0;
        mr_read(1, 2'd3, 32'h20, 8'd7, 1'b1);
        total++; if (ar_lat[1] !== 1) begin bad++; $display("FAIL rd_ar_latency: got %0d want 1", ar_lat[1]); end
        total++; if (rd_cnt[1] !== 8) begin bad++; $display("FAIL rd_beat_count: got %0d want 8", rd_cnt[1]); end
        for (int i = 0; i < 8; i++) begin
            total++; if (rd_data[1][i] !== 32'h20 + i) begin bad++; $display("FAIL rd_beat%0d: got %h want %h", i, rd_data[1][i], 32'h20 + i); end
        end
        total++; if (rd_last[1] !== 16'h0080) begin bad++; $display("FAIL rd_rlast_pos: got %h want 0080", rd_last[1]); end
        total++; if (rd_id[1] !== 2'd3) begin bad++; $display("FAIL rd_rid: got %0d want 3", rd_id[1]); end
        total++; if (s0_rv_seen !== 0) begin bad++; $display("FAIL rd_s0_rvalid: got %0d cycles want 0", s0_rv_seen); end
    endtask

    task automatic test_concurrent();
        logic [1:0] b;
        sl_wcnt = 0;
        fork
            mw_write(0, 2'd1, 32'h60, 8'd0, 32'h77, b);
            mr_read(1, 2'd0, 32'h30, 8'd1, 1'b0);
        join
        total++; if ({aw_lat[0], ar_lat[1]} !== {32'd1, 32'd1}) begin bad++; $display("FAIL cc_grant_latency: aw %0d ar %0d want 1/1", aw_lat[0], ar_lat[1]); end
        total++; if (b_hs_cyc[0] - aw_hs_cyc[0] !== 2) begin bad++; $display("FAIL cc_write_span: got %0d want 2", b_hs_cyc[0] - aw_hs_cyc[0]); end
        total++; if (r_end_cyc[1] - ar_hs_cyc[1] !== 2) begin bad++; $display("FAIL cc_read_span: got %0d want 2", r_end_cyc[1] - ar_hs_cyc[1]); end
        total++; if ({rd_data[1][0], rd_data[1][1]} !== {32'h30, 32'h31}) begin bad++; $display("FAIL cc_read_data: got %h %h want 30 31", rd_data[1][0], rd_data[1][1]); end
        total++; if ({b, sl_wlog[0]} !== {2'd1, 32'h77}) begin bad++; $display("FAIL cc_write_result: bid %0d data %h want 1/77", b, sl_wlog[0]); end
    endtask

    task automatic test_early_w();
        logic [1:0] b0, b1;
        sl_wcnt = 0; early_viol = 0; aw_done[1] = 0;
        fork
            mw_write(0, 2'd0, 32'h80, 8'd3, 32'hB0, b0);
            begin
                repeat (2) @(negedge clk);
                wvalid[1] = 1; wdata[1] = 32'hC0; wlast[1] = 0;
                repeat (3) @(negedge clk);
                mw_write(1, 2'd1, 32'h90, 8'd3, 32'hC0, b1);
            end
        join
        total++; if (early_viol !== 0) begin bad++; $display("FAIL ew_wready_early: got %0d cycles want 0", early_viol); end
        total++; if (sl_wcnt !== 8) begin bad++; $display("FAIL ew_beat_count: got %0d want 8", sl_wcnt); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (sl_wlog[i] !== ((i < 4) ? 32'hB0 + i : 32'hC0 + (i - 4))) begin
                bad++; $display("FAIL ew_order beat%0d: got %h want %h", i, sl_wlog[i], (i < 4) ? 32'hB0 + i : 32'hC0 + (i - 4));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [1:0]  b;
        logic [14:0] flags;
        sl_wcnt = 0;
        awvalid[0] = 1; awid[0] = 2'd1; awaddr[0] = 32'h40; awlen[0] = 8'd3;
        @(negedge clk);
        @(negedge clk);
        awvalid[0] = 0; wvalid[0] = 1; wdata[0] = 32'hD0; wlast[0] = 0;
        @(negedge clk);
        wdata[0] = 32'hD1;
        @(negedge clk);
        wdata[0] = 32'hD2;
        #2;
        total++; if ({m_if.wvalid, sl_wcnt[7:0]} !== {1'b1, 8'd2}) begin bad++; $display("FAIL rm_pre_state: wvalid %b beats %0d want 1/2", m_if.wvalid, sl_wcnt); end
        rst = 1;
        #1;
        flags = {awready_o[0], wready_o[0], bvalid_o[0], arready_o[0], rvalid_o[0],
                 awready_o[1], wready_o[1], bvalid_o[1], arready_o[1], rvalid_o[1],
                 m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
        total++; if (flags !== 15'd0) begin bad++; $display("FAIL rm_async_clear: got %b want 0", flags); end
        @(negedge clk);
        wvalid[0] = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        mw_write(1, 2'd3, 32'h50, 8'd0, 32'hE0, b);
        total++; if (aw_lat[1] !== 1) begin bad++; $display("FAIL rm_regrant_latency: got %0d want 1", aw_lat[1]); end
        total++; if (b !== 2'd3) begin bad++; $display("FAIL rm_regrant_bid: got %0d want 3", b); end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            awaddr[i] = 0; awid[i] = 0; awlen[i] = 0; awvalid[i] = 0;
            wdata[i] = 0; wlast[i] = 0; wvalid[i] = 0; bready[i] = 0;
            araddr[i] = 0; arid[i] = 0; arlen[i] = 0; arvalid[i] = 0; rready[i] = 0;
            aw_done[i] = 0; rd_cnt[i] = 0; rd_last[i] = 0;
        end
        test_reset();
        test_simultaneous_write();
        test_single_write();
        test_read_backpressure();
        test_concurrent();
        test_early_w();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi_arb_2to1.md
# axi_arb_2to1

Two-master, one-slave AXI4 arbiter that shares a single memory-mapped AXI4 slave (e.g. the on-chip 256-byte burst memory) between two AXI4 masters. Write and read paths are arbitrated independently, each with round-robin priority and a grant locked for the full burst: write from AW acceptance to B handshake, read from AR acceptance to the RLAST handshake. One transaction per direction is outstanding at a time. Response routing therefore uses the held grant, and IDs pass through unmodified.

## Interface
Parameters:
- AXI_ID_WD, 2, ID width on all ports
- AXI_DATA_WD, 32, data width
- AXI_ADDR_WD, 32, address width
- AXI_STRB_WD, 4, write-strobe width (AXI_DATA_WD/8)

Ports (clock and reset first):
- ACLK  in  1  single clock for all logic
- ARESET  in  1  asynchronous, active-high reset
- Sn_AXI_AWADDR/AWID/AWBURST/AWSIZE/AWLEN/AWVALID  in  AW/IW/2/3/8/1  write address from master n (n = 0, 1)
- Sn_AXI_AWREADY  out  1  write address ready to master n
- Sn_AXI_WDATA/WSTRB/WLAST/WVALID  in  DW/SW/1/1  write data from master n
- Sn_AXI_WREADY  out  1  write data ready to master n
- Sn_AXI_BID/BRESP/BVALID  out  IW/2/1  write response to master n
- Sn_AXI_BREADY  in  1  write response ready from master n
- Sn_AXI_ARADDR/ARID/ARBURST/ARSIZE/ARLEN/ARVALID  in  AW/IW/2/3/8/1  read address from master n
- Sn_AXI_ARREADY  out  1  read address ready to master n
- Sn_AXI_RDATA/RID/RRESP/RLAST/RVALID  out  DW/IW/2/1/1  read data to master n
- Sn_AXI_RREADY  in  1  read data ready from master n
- M_AXI_AW*/W*/B*/AR*/R*: the same signals toward the slave, with directions mirrored

## Operation
Write FSM:
- States: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: if any Sn_AXI_AWVALID, register wgnt and go to W_ADDR.
  - Only one requester: that master wins.
  - Both requesting: the master selected by wprio wins.
- W_ADDR: M_AXI_AW* = S[wgnt]_AXI_AW*, and S[wgnt]_AXI_AWREADY = M_AXI_AWREADY. On M_AXI_AWVALID && M_AXI_AWREADY go to W_DATA.
- W_DATA: M_AXI_W* = S[wgnt]_AXI_W*, and S[wgnt]_AXI_WREADY = M_AXI_WREADY. On a W handshake with WLAST = 1 go to W_RESP.
- W_RESP: M_AXI_BREADY = S[wgnt]_AXI_BREADY, and S[wgnt]_AXI_BVALID = M_AXI_BVALID. On a B handshake go to W_IDLE and set wprio to the master that did not hold the grant (~wgnt).

Read FSM:
- States: R_IDLE, R_ADDR, R_DATA.
- R_IDLE / R_ADDR: same selection and AR forwarding as the write path, using rgnt and rprio.
- R_DATA: M_AXI_RREADY = S[rgnt]_AXI_RREADY, and S[rgnt]_AXI_RVALID = M_AXI_RVALID. On an R handshake with RLAST = 1 go to R_IDLE and set rprio to ~rgnt.

Gating and pass-through:
- Every READY/VALID toward a non-granted master, or in a state not listed above, is 0. M-side VALIDs are 0 outside their forwarding state.
- Payloads (BID/BRESP/RDATA/RID/RRESP/RLAST) are broadcast from the M side to both masters unchanged; only VALID is gated.
- M-side AW/W/AR payloads are muxed by the grant register in every state.
- A master's W beats presented before its AW is forwarded are stalled (WREADY = 0) and never forwarded.

## Timing
- Reset:
  - States go to IDLE; wgnt, rgnt, wprio, rprio go to 0.
  - All Sn_*READY, Sn_*VALID and M_*VALID outputs are 0 immediately (asynchronous reset), and stay 0 until the first post-reset grant.
  - Payload outputs follow master 0 / slave inputs.
- Arbitration latency: 1 cycle. AWVALID (ARVALID) rising in IDLE gives M_AXI_AWVALID (ARVALID) on the next cycle.
- All forwarding is combinational in the granted state: zero added latency per beat, full throughput within a burst.
- Turnaround: after the closing B or RLAST handshake, one IDLE cycle precedes the next grant.
- Grant stability:
  - wgnt/rgnt change only in IDLE.
  - A requester dropping VALID before its grant is accepted is outside the AXI rules; the arbiter still completes its FSM per the handshakes.
- Independence: write and read FSMs never block each other, so a read and a write from different masters run concurrently.
- Reset mid-burst abandons the transaction with no recovery. The slave must be reset together with the arbiter.

## Test plan
- **Single write:** M0 AW (addr 0x10, len 3) plus 4 beats 0xA0..0xA3 → M side shows AWVALID 1 cycle after request, 4 beats with WLAST on the 4th. S0 gets BVALID with BID = M0's AWID. S1 sees all READY/VALID = 0.
- **Simultaneous write:** M0 and M1 raise AWVALID in the same cycle after reset → M0 served first. After M0's B handshake, one idle cycle, then M1 granted. Next tie goes to M0 again.
- **Read burst with backpressure:** M1 reads addr 0x20, len 7; S1_RREADY toggles every other cycle → 8 beats delivered in order with RLAST on the 8th; S0_RVALID stays 0 throughout.
- **Concurrent read and write:** M0 writes (len 0) while M1 reads (len 1) in the same cycle → both grants issued the next cycle and both complete with no added stall.
- **Async reset mid-burst:** assert ARESET between beat 2 and beat 3 of a write → all VALID/READY outputs are 0 within the same cycle. After release, a fresh M1 write is granted in 1 cycle.
- **Early W:** M1 drives WVALID 3 cycles before its AWVALID while M0 holds the write grant → S1_WREADY stays 0 until M1's AW is forwarded, and no M1 beat reaches the M side early.
